vga_frame_receiver: RTL and testbench
=====================================

# vga_frame_receiver

Receive-side counterpart of the on-chip VGA sprite output path (hvsync_generator plus sprite colour logic). It samples hsync, vsync and 4-bit RGB, recovers pixel coordinates, and locks to 640x480 timing. Each frame it reports the bounding box of lit pixels, so the walking sprite's position can be checked in silicon loopback and in simulation without a monitor.

## Interface
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, front-porch pixels
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, back-porch pixels (H_TOTAL = 800)
- V_DISPLAY, 480, active lines
- V_BOTTOM, 10, bottom-porch lines
- V_SYNC, 2, vsync pulse lines
- V_TOP, 33, top-porch lines (V_TOTAL = 525)
- SYNC_ACTIVE_LOW, 1, sync polarity of hsync/vsync inputs
- clk  in  1  pixel clock, same clock as the VGA generator
- reset  in  1  synchronous, active-high
- hsync, vsync  in  1 each  sync inputs, polarity per SYNC_ACTIVE_LOW
- r, g, b  in  4 each  colour inputs
- locked  out  1  timing lock acquired
- sync_err  out  1  one-cycle pulse on a timing violation while locked
- pixel_x, pixel_y  out  10 each  recovered coordinate of the pixel in the output stage
- pixel_active  out  1  pixel_x < H_DISPLAY and pixel_y < V_DISPLAY, and locked
- frame_done  out  1  one-cycle pulse when the bbox outputs update
- bbox_valid  out  1  previous frame contained at least one lit pixel
- bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax  out  10 each  bounding box of the previous frame

## Operation
- Stage 1 registers all inputs. Sync is normalised to active-high (hs_a, vs_a). The leading edge is hs_a & ~hs_a_d (likewise for vs).
- h_cnt: free-running 0..H_TOTAL-1. On an h leading edge, the stage-1 pixel takes position H_DISPLAY+H_FRONT (656); otherwise it takes the h_cnt prediction. h_cnt advances from that value and wraps to 0.
- v_cnt increments when h_cnt wraps, modulo V_TOTAL. On a v leading edge, the current line becomes V_DISPLAY+V_BOTTOM (490).
- Mismatch: the predicted position at an edge differs from 656 (h) or 490 (v). Edges that occur during SEARCH never count as mismatches.
- FSM states are SEARCH, MEASURE and LOCKED.
  - SEARCH: go to MEASURE on a v edge.
  - MEASURE: any mismatch restarts MEASURE with counters reloaded. The next v edge with no mismatch during the frame goes to LOCKED.
  - LOCKED: any mismatch produces sync_err and a transition to SEARCH.
- Lit pixel: r|g|b nonzero.
- Accumulation happens only in LOCKED while the pixel is active. It updates xmin, xmax, ymin, ymax and the any_lit flag.
  - Accumulator reset values: min = 10'h3FF, max = 0, any_lit = 0.
- On a v edge while LOCKED with no mismatch:
  - Copy the accumulators to the bbox outputs, setting bbox_valid = any_lit.
  - Pulse frame_done.
  - Clear the accumulators.
- On entry to LOCKED: clear the accumulators. No frame_done is issued.
- Lit pixels in blanking, and lit pixels while not LOCKED, are ignored.

## Timing
- Latency from input pins to pixel_x, pixel_y and pixel_active is 2 cycles.
- locked rises in the cycle after the qualifying v edge is detected.
- sync_err is a single-cycle pulse in the cycle after mismatch detection. locked falls in that same cycle.
- frame_done pulses in the cycle after the v edge. The bbox outputs are valid in that cycle and hold until the next frame_done.
- Simultaneous h and v edges are legal (the generator asserts vsync at hpos 0 is not the case here). Both edges are checked in the same cycle.
- Reset values: locked 0, sync_err 0, frame_done 0, bbox_valid 0, all bbox outputs 0, pixel_x 0, pixel_y 0, pixel_active 0, FSM in SEARCH.
- Reset mid-frame takes effect on the next edge. The frame in progress is discarded.

## Structure
- A shared package vga_timing_pkg holds the H_/V_ timing constants and derived H_TOTAL, V_TOTAL, H_SYNC_START and V_SYNC_START. The generator side uses the same package.
- FSM state enum: lives in the package.
- Sub-module: vga_bbox_accum, containing the min/max/any_lit accumulator and the output latch.

## Test plan
- Reset, clean 640x480 timing, black pixels: locked=1 after the 2nd v edge. The 3rd v edge gives frame_done with bbox_valid=0.
- 16x16 yellow block at x 100..115, y 100..115: bbox = (100, 115, 100, 115), bbox_valid=1.
- Block shifted +1 px per frame for 5 frames: bbox_xmin steps 100→104 across successive frame_done pulses.
- Single lit pixel at x=700 (blanking) plus block at (300, 200): bbox = (300, 315, 200, 215), with the blanking pixel excluded.
- While locked, one line shortened to 790 clocks: sync_err pulses once and locked=0. Relock occurs after 2 further clean v edges, with no frame_done in between.
- reset pulse mid-frame at line 240: all outputs return to reset values in the next cycle. The lock sequence repeats as in the first scenario.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants, receiver FSM states and bbox types.
// Used by both the sync generator and the frame receiver.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_BOTTOM  = 10;
    localparam int V_SYNC    = 2;
    localparam int V_TOP     = 33;

    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;
    localparam coord_t COORD_MAX = '1;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } rx_state_t;

    typedef struct packed {
        coord_t xmin;
        coord_t xmax;
        coord_t ymin;
        coord_t ymax;
    } bbox_t;

    localparam bbox_t BBOX_EMPTY = '{xmin: COORD_MAX, xmax: '0, ymin: COORD_MAX, ymax: '0};

    function automatic logic is_lit(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        return |{r, g, b};
    endfunction

    // Next raster position along one axis, wrapping at last.
    function automatic coord_t next_pos(input coord_t pos, input coord_t last);
        return (pos == last) ? '0 : pos + coord_t'(1);
    endfunction

endpackage

// File: rtl/vga_bbox_accum.sv
// Per-frame min/max accumulator of lit pixel coordinates plus the output latch.
// Latency: latch -> frame_done/bbox outputs 1 cycle; no backpressure, acc_en is sampled every cycle.
module vga_bbox_accum (
    input  logic       clk,
    input  logic       reset,
    input  logic       acc_en,
    input  logic       clear,
    input  logic       latch,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       frame_done,
    output logic       bbox_valid,
    output logic [9:0] bbox_xmin,
    output logic [9:0] bbox_xmax,
    output logic [9:0] bbox_ymin,
    output logic [9:0] bbox_ymax
);
    import vga_timing_pkg::*;

    bbox_t acc;
    bbox_t out_box;
    logic  any_lit;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= BBOX_EMPTY;
            any_lit    <= 1'b0;
            out_box    <= '0;
            bbox_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= latch;
            if (latch) begin
                out_box    <= acc;
                bbox_valid <= any_lit;
            end
            // A closing or opening frame boundary always starts from empty.
            if (latch || clear) begin
                acc     <= BBOX_EMPTY;
                any_lit <= 1'b0;
            end else if (acc_en) begin
                if (x < acc.xmin) acc.xmin <= x;
                if (x > acc.xmax) acc.xmax <= x;
                if (y < acc.ymin) acc.ymin <= y;
                if (y > acc.ymax) acc.ymax <= y;
                any_lit <= 1'b1;
            end
        end
    end

    assign bbox_xmin = out_box.xmin;
    assign bbox_xmax = out_box.xmax;
    assign bbox_ymin = out_box.ymin;
    assign bbox_ymax = out_box.ymax;

endmodule

// File: rtl/vga_frame_receiver.sv
// VGA receiver: recovers pixel coordinates from hsync/vsync, locks to the timing, reports lit-pixel bbox per frame.
// Latency: pins -> pixel_x/y/active 2 cycles; v edge -> frame_done 1 cycle after detection; no backpressure.
module vga_frame_receiver #(
    parameter int H_DISPLAY       = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT         = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC          = vga_timing_pkg::H_SYNC,
    parameter int H_BACK          = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY       = vga_timing_pkg::V_DISPLAY,
    parameter int V_BOTTOM        = vga_timing_pkg::V_BOTTOM,
    parameter int V_SYNC          = vga_timing_pkg::V_SYNC,
    parameter int V_TOP           = vga_timing_pkg::V_TOP,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [3:0] r,
    input  logic [3:0] g,
    input  logic [3:0] b,
    output logic       locked,
    output logic       sync_err,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_active,
    output logic       frame_done,
    output logic       bbox_valid,
    output logic [9:0] bbox_xmin,
    output logic [9:0] bbox_xmax,
    output logic [9:0] bbox_ymin,
    output logic [9:0] bbox_ymax
);
    import vga_timing_pkg::*;

    localparam coord_t H_LAST     = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t V_LAST     = coord_t'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
    localparam coord_t H_EDGE_POS = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t V_EDGE_POS = coord_t'(V_DISPLAY + V_BOTTOM);
    localparam coord_t H_ACT      = coord_t'(H_DISPLAY);
    localparam coord_t V_ACT      = coord_t'(V_DISPLAY);

    // Stage 1: registered pins, sync normalised to active-high.
    logic       hs_a, vs_a, hs_a_d, vs_a_d;
    logic [3:0] r_s, g_s, b_s;

    // Delayed syncs reset to asserted so a pulse already in progress at reset is not taken as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_a   <= 1'b1;
            vs_a   <= 1'b1;
            hs_a_d <= 1'b1;
            vs_a_d <= 1'b1;
            r_s    <= '0;
            g_s    <= '0;
            b_s    <= '0;
        end else begin
            hs_a   <= hsync ^ SYNC_ACTIVE_LOW;
            vs_a   <= vsync ^ SYNC_ACTIVE_LOW;
            hs_a_d <= hs_a;
            vs_a_d <= vs_a;
            r_s    <= r;
            g_s    <= g;
            b_s    <= b;
        end
    end

    logic   h_edge, v_edge, h_mis, v_mis, mis, h_wrap;
    coord_t h_cnt, v_cnt, h_pos, v_pos;

    // h_cnt/v_cnt hold the predicted position of the current stage-1 pixel.
    always_comb begin
        h_edge = hs_a & ~hs_a_d;
        v_edge = vs_a & ~vs_a_d;
        h_pos  = h_edge ? H_EDGE_POS : h_cnt;
        v_pos  = v_edge ? V_EDGE_POS : v_cnt;
        h_wrap = (h_pos == H_LAST);
        h_mis  = h_edge && (h_cnt != H_EDGE_POS);
        v_mis  = v_edge && (v_cnt != V_EDGE_POS);
        mis    = h_mis | v_mis;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= next_pos(h_pos, H_LAST);
            v_cnt <= h_wrap ? next_pos(v_pos, V_LAST) : v_pos;
        end
    end

    rx_state_t state, state_nxt;
    logic      meas_dirty, meas_dirty_nxt;
    logic      err_nxt, latch_bbox, clear_acc;

    // meas_dirty marks a MEASURE frame broken mid-way; the next v edge only restarts the measurement.
    always_comb begin
        state_nxt      = state;
        meas_dirty_nxt = meas_dirty;
        err_nxt        = 1'b0;
        latch_bbox     = 1'b0;
        clear_acc      = 1'b0;
        unique case (state)
            ST_SEARCH: begin
                if (v_edge) begin
                    state_nxt      = ST_MEASURE;
                    meas_dirty_nxt = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (mis) begin
                    meas_dirty_nxt = ~v_edge;
                end else if (v_edge) begin
                    if (meas_dirty) begin
                        meas_dirty_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_LOCKED;
                        clear_acc = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (mis) begin
                    state_nxt = ST_SEARCH;
                    err_nxt   = 1'b1;
                end else if (v_edge) begin
                    latch_bbox = 1'b1;
                end
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_SEARCH;
            meas_dirty <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            meas_dirty <= meas_dirty_nxt;
            sync_err   <= err_nxt;
        end
    end

    assign locked = (state == ST_LOCKED);

    logic act_s1, lit_s1;
    assign act_s1 = (h_pos < H_ACT) && (v_pos < V_ACT) && locked;
    assign lit_s1 = is_lit(r_s, g_s, b_s);

    // Stage 2: output coordinate register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_x      <= '0;
            pixel_y      <= '0;
            pixel_active <= 1'b0;
        end else begin
            pixel_x      <= h_pos;
            pixel_y      <= v_pos;
            pixel_active <= act_s1;
        end
    end

    vga_bbox_accum u_bbox_accum (
        .clk        (clk),
        .reset      (reset),
        .acc_en     (act_s1 & lit_s1),
        .clear      (clear_acc),
        .latch      (latch_bbox),
        .x          (h_pos),
        .y          (v_pos),
        .frame_done (frame_done),
        .bbox_valid (bbox_valid),
        .bbox_xmin  (bbox_xmin),
        .bbox_xmax  (bbox_xmax),
        .bbox_ymin  (bbox_ymin),
        .bbox_ymax  (bbox_ymax)
    );

endmodule

// File: tb/tb_vga_frame_receiver.sv
// Directed bench for vga_frame_receiver on a scaled-down raster (32x26 clocks per frame).
// A behavioural sync generator drives the pins; expected values are fixed by hand per scenario.
module tb_vga_frame_receiver;

    localparam int HD = 24, HF = 2, HS = 4, HB = 2;
    localparam int VD = 20, VB = 2, VS = 2, VT = 2;
    localparam int HT    = HD + HF + HS + HB;   // 32
    localparam int VTOT  = VD + VB + VS + VT;   // 26
    localparam int HSS   = HD + HF;             // 26
    localparam int VSS   = VD + VB;             // 22
    localparam int FRAME = HT * VTOT;           // 832

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync, vsync;
    logic [3:0] r, g, b;
    logic       locked, sync_err, pixel_active, frame_done, bbox_valid;
    logic [9:0] pixel_x, pixel_y, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;

    always #5 clk = ~clk;

    vga_frame_receiver #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .r(r), .g(g), .b(b),
        .locked(locked), .sync_err(sync_err),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_active(pixel_active),
        .frame_done(frame_done), .bbox_valid(bbox_valid),
        .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
        .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Generator and monitor state
    int hpos = 0, vpos = 0, line_len = HT;
    int drv_h, drv_v;
    bit drove_vedge;
    bit blk_on = 0, px_on = 0;
    int blk_x = 0, blk_y = 0, px_x = 0, px_y = 0;
    int cyc = 0, vedge_cyc = 0, fd_lat = -1;
    int fd_cnt = 0, err_cnt = 0, fd_mark;
    logic err_locked = 1'b1;

    task automatic monitor();
        cyc++;
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_lat = cyc - vedge_cyc;
        end
        if (sync_err === 1'b1) begin
            err_cnt++;
            err_locked = locked;
        end
    endtask

    task automatic drive();
        bit hs_act, vs_act, lit;
        hs_act = (hpos >= HSS) && (hpos < HSS + HS);
        vs_act = (vpos >= VSS) && (vpos < VSS + VS);
        hsync  = ~hs_act;
        vsync  = ~vs_act;
        lit = (blk_on && hpos >= blk_x && hpos < blk_x + 4 && vpos >= blk_y && vpos < blk_y + 4)
           || (px_on && hpos == px_x && vpos == px_y);
        r = lit ? 4'hF : 4'h0;
        g = lit ? 4'hF : 4'h0;
        b = 4'h0;
        drv_h = hpos;
        drv_v = vpos;
        drove_vedge = (vpos == VSS) && (hpos == 0);
        if (drove_vedge) vedge_cyc = cyc;
        if (hpos >= line_len - 1) begin
            hpos     = 0;
            line_len = HT;
            vpos     = (vpos == VTOT - 1) ? 0 : vpos + 1;
        end else begin
            hpos++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        drive();
    endtask

    task automatic run_to(input int x, input int y);
        bit hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            step();
            hit = (drv_h == x) && (drv_v == y);
        end
        check($sformatf("reach_%0d_%0d", x, y), hit, 1);
    endtask

    task automatic wait_vedge();
        bit hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            step();
            hit = drove_vedge;
        end
        check("reach_vedge", hit, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        r = 4'h0; g = 4'h0; b = 4'h0;
        repeat (4) step();
        check("rst_locked", locked, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_bbox_valid", bbox_valid, 0);
        check("rst_bbox_xmin", bbox_xmin, 0);
        check("rst_bbox_ymax", bbox_ymax, 0);
        check("rst_pixel_x", pixel_x, 0);
        check("rst_pixel_active", pixel_active, 0);
        reset = 1'b0;

        // Lock sequence on clean timing with black pixels
        wait_vedge(); step(); step();
        check("unlocked_after_vedge1", locked, 0);
        wait_vedge(); step();
        check("locked_1cyc_after_vedge2", locked, 0);
        step();
        check("locked_2cyc_after_vedge2", locked, 1);
        check("no_fd_on_lock", fd_cnt, 0);

        // Coordinate recovery, 2-cycle latency
        run_to(5, 3); step(); step();
        check("pixel_x_5", pixel_x, 5);
        check("pixel_y_3", pixel_y, 3);
        check("pixel_active_in", pixel_active, 1);
        run_to(27, 3); step(); step();
        check("pixel_x_27", pixel_x, 27);
        check("pixel_active_blank", pixel_active, 0);

        // Third v edge: empty frame reported
        wait_vedge();
        blk_on = 1; blk_x = 4; blk_y = 4;
        step();
        check("fd_1cyc", frame_done, 0);
        step();
        check("fd_2cyc", frame_done, 1);
        check("fd_latency", fd_lat, 2);
        check("fd_count_1", fd_cnt, 1);
        check("empty_bbox_valid", bbox_valid, 0);

        // 4x4 block walking right one pixel per frame
        for (int i = 0; i < 5; i++) begin
            wait_vedge(); step(); step();
            check($sformatf("walk%0d_fd", i), frame_done, 1);
            check($sformatf("walk%0d_xmin", i), bbox_xmin, 4 + i);
            check($sformatf("walk%0d_xmax", i), bbox_xmax, 7 + i);
            if (i == 0) begin
                check("blk_ymin", bbox_ymin, 4);
                check("blk_ymax", bbox_ymax, 7);
                check("blk_valid", bbox_valid, 1);
            end
            blk_x = 5 + i;
        end

        // Lit pixel in horizontal blanking must not widen the box
        blk_x = 12; blk_y = 10;
        px_on = 1; px_x = 27; px_y = 5;
        wait_vedge(); step(); step();
        check("blank_xmin", bbox_xmin, 12);
        check("blank_xmax", bbox_xmax, 15);
        check("blank_ymin", bbox_ymin, 10);
        check("blank_ymax", bbox_ymax, 13);
        check("blank_valid", bbox_valid, 1);
        px_on  = 0;
        blk_on = 0;

        // One short line while locked
        run_to(0, 8);
        line_len = HT - 4;
        wait_vedge();
        check("sync_err_pulses", err_cnt, 1);
        check("locked_during_err", err_locked, 0);
        check("unlocked_after_err", locked, 0);
        fd_mark = fd_cnt;
        step(); step();
        blk_on = 1; blk_x = 4; blk_y = 4;
        check("relock_wait_vedgeA", locked, 0);
        wait_vedge(); step(); step();
        check("relocked_vedgeB", locked, 1);
        check("no_fd_during_relock", fd_cnt, fd_mark);
        check("sync_err_still_1", err_cnt, 1);
        wait_vedge(); step(); step();
        check("relock_fd", frame_done, 1);
        check("relock_bbox_xmin", bbox_xmin, 4);
        check("relock_bbox_ymax", bbox_ymax, 7);
        check("relock_bbox_valid", bbox_valid, 1);

        // Reset mid-frame
        run_to(0, 12);
        check("pre_reset_locked", locked, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_locked", locked, 0);
        check("mid_rst_bbox_valid", bbox_valid, 0);
        check("mid_rst_bbox_xmin", bbox_xmin, 0);
        check("mid_rst_bbox_xmax", bbox_xmax, 0);
        check("mid_rst_pixel_y", pixel_y, 0);
        check("mid_rst_pixel_active", pixel_active, 0);
        fd_mark = fd_cnt;
        wait_vedge();
        wait_vedge(); step(); step();
        check("post_rst_locked", locked, 1);
        check("post_rst_no_fd", fd_cnt, fd_mark);
        wait_vedge(); step(); step();
        check("post_rst_fd", frame_done, 1);
        check("post_rst_bbox_valid", bbox_valid, 1);
        check("post_rst_bbox_xmin", bbox_xmin, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
